// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the instruction fetch front
//                end: fetch FSM states, queue entry layout, word stepping.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN       = 32;
    localparam int WORD_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_BUSY = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Address of the next sequential instruction word (wraps modulo 2^32).
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + XLEN'(WORD_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Bundle of the instruction-memory handshake, ID-stage control
//                and IF_ID-facing head-entry signals of the fetch queue.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_queue_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instruction;
    logic [CW-1:0]   count;

    // The fetch queue side.
    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instruction, count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, stall
    );

    // The memory / pipeline side.
    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instruction, count,
        output imem_ack, imem_rdata, redirect, redirect_pc, stall
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH-entry circular buffer of {pc, instruction} pairs with
//                push, pop, synchronous flush and occupancy count.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          flush_i,
    input  wire logic          push_i,
    input  wire fetch_entry_t  push_data_i,
    input  wire logic          pop_i,
    output fetch_entry_t       head_o,
    output logic               head_valid_o,
    output logic [CW-1:0]      count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // A flush overrides any same-edge push or pop.
    assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i  && !flush_i && (count_q != '0);

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by count so need no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign head_valid_o = (count_q != '0);
    assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch front end feeding IF_ID. Owns the fetch PC,
//                runs the imem req/ack handshake, buffers fetched words and
//                honours ID-stage redirects and IF_ID stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input wire logic      clock,
    input wire logic      reset,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] held_addr_q;

    logic            fifo_full;
    logic            req;
    logic            fire;
    logic            push;
    logic            pop;
    logic            head_valid;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic [CW-1:0]   occupancy;

    assign fifo_full = (occupancy == CW'(DEPTH));

    // Once raised, a request stays up until acked because state leaves IDLE.
    // A redirect suppresses only a brand new request.
    assign req  = reset && ((state_q != FETCH_IDLE) || (!fifo_full && !bus.redirect));
    assign fire = req && bus.imem_ack;

    // Results returned in DROP, or alongside a redirect, are stale.
    assign push = fire && !bus.redirect && (state_q != FETCH_DROP);
    assign pop  = head_valid && !bus.stall && !bus.redirect;

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = bus.imem_rdata;

    // Fetch PC follows a redirect, otherwise steps one word per accepted fetch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (push) begin
            fetch_pc_d = next_word(fetch_pc_q);
        end
    end

    // Fetch handshake FSM, fetch PC and the address held while dropping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= FETCH_IDLE;
            fetch_pc_q  <= RESET_PC;
            held_addr_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            case (state_q)
                FETCH_IDLE: begin
                    if (req && !bus.imem_ack) begin
                        state_q <= FETCH_BUSY;
                    end
                end
                FETCH_BUSY: begin
                    if (bus.imem_ack) begin
                        state_q <= FETCH_IDLE;
                    end else if (bus.redirect) begin
                        // Keep presenting the outstanding address until acked.
                        held_addr_q <= fetch_pc_q;
                        state_q     <= FETCH_DROP;
                    end
                end
                FETCH_DROP: begin
                    if (bus.imem_ack) begin
                        state_q <= FETCH_IDLE;
                    end
                end
                default: state_q <= FETCH_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .flush_i      (bus.redirect),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .head_valid_o (head_valid),
        .count_o      (occupancy)
    );

    assign bus.imem_req        = req;
    assign bus.imem_addr       = (state_q == FETCH_DROP) ? held_addr_q : fetch_pc_q;
    assign bus.out_valid       = reset && head_valid;
    assign bus.out_pc          = bus.out_valid ? head.pc    : '0;
    assign bus.out_instruction = bus.out_valid ? head.instr : '0;
    assign bus.count           = occupancy;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue: a queue-level reference
//                model compared every cycle, plus directed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    bit   cmp_en;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], 16'hBEEF} ^ 32'h1357_0000;
    endfunction

    always_comb bus.imem_rdata = instr_of(bus.imem_addr);

    // Reference model: list of buffered {pc,instr}, fetch PC, and one
    // outstanding request with its address and a "discard" mark.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_paddr;
    bit          m_pend;
    bit          m_dead;

    function automatic bit m_req();
        return reset && (m_pend || ((mq.size() < DEPTH) && !bus.redirect));
    endfunction

    function automatic logic [31:0] m_addr();
        return m_pend ? m_paddr : m_pc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge.
    always @(posedge clock) begin
        bit          r;
        bit          f;
        logic [31:0] a;
        if (!reset) begin
            mq.delete();
            m_pc    <= 32'h0;
            m_pend  <= 1'b0;
            m_dead  <= 1'b0;
            m_paddr <= 32'h0;
        end else begin
            r = m_req();
            f = r && bus.imem_ack;
            a = m_addr();
            if (bus.redirect) begin
                mq.delete();
                m_pc <= bus.redirect_pc;
                if (f) begin
                    m_pend <= 1'b0;
                    m_dead <= 1'b0;
                end else if (m_pend) begin
                    m_dead <= 1'b1;
                end
            end else begin
                if (mq.size() > 0 && !bus.stall) void'(mq.pop_front());
                if (f) begin
                    if (!m_dead) begin
                        mq.push_back({a, instr_of(a)});
                        m_pc <= a + 32'd4;
                    end
                    m_pend <= 1'b0;
                    m_dead <= 1'b0;
                end else if (r) begin
                    m_pend  <= 1'b1;
                    m_paddr <= a;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        bit ev;
        bit er;
        if (cmp_en) begin
            er = m_req();
            chk("imem_req", 64'(bus.imem_req), 64'(er));
            if (er) chk("imem_addr", 64'(bus.imem_addr), 64'(m_addr()));
            ev = reset && (mq.size() > 0);
            chk("out_valid", 64'(bus.out_valid), 64'(ev));
            chk("out_pc", 64'(bus.out_pc), ev ? 64'(mq[0][63:32]) : 64'h0);
            chk("out_instruction", 64'(bus.out_instruction), ev ? 64'(mq[0][31:0]) : 64'h0);
            chk("count", 64'(bus.count), 64'(mq.size()));
        end
    end

    task automatic cyc(input bit r, input bit a, input bit rd, input logic [31:0] rp, input bit s);
        @(posedge clock);
        #1;
        reset           = r;
        bus.imem_ack    = a;
        bus.redirect    = rd;
        bus.redirect_pc = rp;
        bus.stall       = s;
        @(negedge clock);
        #1;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        cmp_en          = 1'b0;
        reset           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.stall       = 1'b0;

        // T1: zero-wait memory, one instruction per cycle.
        cyc(0, 1, 0, 0, 0);
        cmp_en = 1'b1;
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("t1_first_addr", 64'(bus.imem_addr), 64'h0);
        chk("t1_c0_valid", 64'(bus.out_valid), 64'h0);
        cyc(1, 1, 0, 0, 0);
        chk("t1_c1_pc", 64'(bus.out_pc), 64'h0);
        chk("t1_c1_count", 64'(bus.count), 64'd1);
        chk("t1_c1_addr", 64'(bus.imem_addr), 64'h4);
        cyc(1, 1, 0, 0, 0);
        chk("t1_c2_pc", 64'(bus.out_pc), 64'h4);
        chk("t1_c2_count", 64'(bus.count), 64'd1);
        cyc(1, 1, 0, 0, 0);
        chk("t1_c3_pc", 64'(bus.out_pc), 64'h8);

        // T2: stall fills the queue, requests stop, then drain resumes at 16.
        cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 1);
        chk("t2_full_count", 64'(bus.count), 64'd4);
        chk("t2_full_req", 64'(bus.imem_req), 64'h0);
        chk("t2_head_held", 64'(bus.out_pc), 64'h0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("t2_resume_addr", 64'(bus.imem_addr), 64'd16);
        chk("t2_resume_pc", 64'(bus.out_pc), 64'h4);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);

        // T3: ack withheld for three cycles on address 8.
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("t3_wait_addr", 64'(bus.imem_addr), 64'h8);
            chk("t3_wait_req", 64'(bus.imem_req), 64'h1);
        end
        chk("t3_empty", 64'(bus.out_valid), 64'h0);
        cyc(1, 1, 0, 0, 0);
        chk("t3_ack_addr", 64'(bus.imem_addr), 64'h8);
        cyc(1, 1, 0, 0, 0);
        chk("t3_out_pc", 64'(bus.out_pc), 64'h8);
        chk("t3_out_instr", 64'(bus.out_instruction), 64'(32'hBEEF_BEEF ^ 32'h1357_0000 ^ 32'hBEEF_0000 ^ 32'h0008_0000));

        // T4: redirect to 0x40 while waiting on 0xC; stale ack two cycles later.
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t4_busy_addr", 64'(bus.imem_addr), 64'hC);
        cyc(1, 0, 1, 32'h40, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t4_flushed", 64'(bus.out_valid), 64'h0);
        chk("t4_drop_addr", 64'(bus.imem_addr), 64'hC);
        cyc(1, 1, 0, 0, 0);
        chk("t4_drop_ack_addr", 64'(bus.imem_addr), 64'hC);
        cyc(1, 1, 0, 0, 0);
        chk("t4_new_addr", 64'(bus.imem_addr), 64'h40);
        chk("t4_discarded", 64'(bus.count), 64'd0);
        cyc(1, 1, 0, 0, 0);
        chk("t4_new_pc", 64'(bus.out_pc), 64'h40);

        // T5: redirect to 0x80 in the same cycle as ack and a pop.
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 32'h80, 0);
        cyc(1, 1, 0, 0, 0);
        chk("t5_count", 64'(bus.count), 64'd0);
        chk("t5_valid", 64'(bus.out_valid), 64'h0);
        chk("t5_addr", 64'(bus.imem_addr), 64'h80);
        cyc(1, 1, 0, 0, 0);
        chk("t5_pc", 64'(bus.out_pc), 64'h80);

        // T6: reset while a request is outstanding.
        cyc(0, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("t6_busy_addr", 64'(bus.imem_addr), 64'h8);
        cyc(0, 0, 0, 0, 1);
        chk("t6_rst_req", 64'(bus.imem_req), 64'h0);
        chk("t6_rst_valid", 64'(bus.out_valid), 64'h0);
        chk("t6_rst_pc", 64'(bus.out_pc), 64'h0);
        cyc(1, 1, 0, 0, 0);
        chk("t6_after_addr", 64'(bus.imem_addr), 64'h0);
        chk("t6_after_count", 64'(bus.count), 64'd0);
        chk("t6_after_req", 64'(bus.imem_req), 64'h1);

        // Mixed traffic: varied ack latency, stalls and occasional redirects.
        for (int i = 0; i < 80; i++) begin
            cyc(1, ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0),
                {22'h0, 8'($urandom_range(0, 255)), 2'b00}, ($urandom_range(0, 3) == 0));
        end
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the IF_ID pipeline register.
- Owns the fetch PC and issues word fetches to instruction memory over a req/ack handshake with variable latency.
- Buffers up to DEPTH fetched {pc, instruction} pairs and presents the head entry to IF_ID.
- Honours ID-stage redirects (jump/jr/branch) and IF_ID stalls (load-use hazard).

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address, equals fetch_pc or held address
imem_ack  input  1  memory accepts req and returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid when imem_req && imem_ack
redirect  input  1  ID-stage redirect (s_npc != 00), single-cycle pulse or level
redirect_pc  input  32  new fetch target, valid with redirect
stall  input  1  IF_ID_write deasserted: head must not be consumed
out_valid  output  1  head entry valid
out_pc  output  32  head entry pc (0 when empty)
out_instruction  output  32  head entry instruction (0 when empty)
count  output  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (reset==0 at edge): fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=IDLE, held address=0. While reset is low, imem_req=0, out_valid=0, and out_pc/out_instruction=0.
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: request issued, no ack yet; address held.
  - DROP: request outstanding but result must be discarded after a redirect.
- imem_req = (state!=IDLE) || (count<DEPTH && !redirect). A request, once raised, is never withdrawn before ack.
- imem_addr = fetch_pc in IDLE/BUSY; the held (stale) address in DROP.
- IDLE:
  - req && ack: push {fetch_pc, imem_rdata}, fetch_pc += 4, stay IDLE. A zero-wait memory therefore sustains 1 instruction/cycle.
  - req && !ack: go BUSY.
- BUSY:
  - ack && !redirect: push, fetch_pc += 4, go IDLE.
  - ack && redirect: discard rdata, go IDLE.
  - !ack && redirect: latch held address = fetch_pc, go DROP.
- DROP: on ack, discard rdata and go IDLE. A further redirect in DROP only updates fetch_pc.
- Any redirect, any state: fetch_pc <= redirect_pc, queue flushed (count=0, pointers reset) at that edge. The same-edge push and pop are ignored.
- Pop when out_valid && !stall && !redirect. A simultaneous push and pop leaves count unchanged.
- Latency: an instruction acked at edge N is visible on out_* in cycle N+1. There is no combinational bypass from imem_rdata to out_*.
- Full (count==DEPTH): no new request is raised. An outstanding request can only exist when count<DEPTH at issue, so a push never overflows.
- Empty: pop is a no-op and out_valid=0.
- Pointers wrap modulo DEPTH; fetch_pc wraps modulo 2^32.
- Reset mid-request abandons the handshake. Instruction memory is reset on the same reset.

Decomposition:
- Shared package cpu_pkg:
  - fetch FSM state encoding (IDLE, BUSY, DROP)
  - WORD_BYTES=4
  - RESET_PC default
  - 32-bit instruction/address width constants
- One sub-module: fetch_fifo. It is a DEPTH×64 circular buffer with push, pop, synchronous flush and count. It is instantiated once; fetch_queue holds the FSM and fetch_pc.

Test Plan:
- Zero-wait memory (ack tied 1), pulse reset, no stall → imem_addr 0,4,8,…; out_valid from cycle 2; out_pc 0,4,8 on consecutive cycles; count stays 1.
- stall=1 for 6 cycles with ack=1 → count reaches 4, imem_req drops to 0, out_pc held at head. stall=0 → one pop per cycle, requests resume at fetch_pc=16.
- ack delayed 3 cycles on addr 8 → imem_req and imem_addr=8 held stable across the wait; entry pc=8 pushed on the ack edge and appears one cycle later.
- redirect to 0x40 while BUSY on addr 0xC (ack 2 cycles later) → queue flushed, out_valid=0 next cycle, state DROP with imem_addr=0xC until ack, rdata discarded, next request addr 0x40.
- redirect to 0x80 in the same cycle as ack and as a pop → no push, count=0, next imem_addr=0x80, first valid out_pc=0x80.
- reset asserted low while BUSY → imem_req=0 and out_valid=0 during reset. After release, first imem_addr=RESET_PC and count=0.
